// File: rtl/ex_stage_div_pkg.sv
// ---------------------------------------------------------------------------
// ex_stage_div_pkg
// Shared definitions for the execute stage:
//   - field layout of the decode->execute, execute->memory and
//     execute->decode buses (packed structs, MSB first)
//   - div_op bit indices
//   - divider FSM state encoding
// ---------------------------------------------------------------------------
package ex_stage_div_pkg;

    localparam int DATA_W     = 32;
    localparam int ALU_OP_W   = 12;
    localparam int DIV_OP_W   = 3;
    localparam int REG_ADDR_W = 5;
    localparam int DIV_CNT_W  = 5;

    // div_op bit positions
    localparam int DIV_IS_DIV   = 2;
    localparam int DIV_SIGNED   = 1;
    localparam int DIV_WANT_REM = 0;

    // Decode -> execute bus, MSB first.
    typedef struct packed {
        logic [DATA_W-1:0]     pc;
        logic [ALU_OP_W-1:0]   alu_op;
        logic [DATA_W-1:0]     alu_src1;
        logic [DATA_W-1:0]     alu_src2;
        logic [DIV_OP_W-1:0]   div_op;
        logic                  res_from_mem;
        logic                  mem_we;
        logic                  rf_we;
        logic [REG_ADDR_W-1:0] rf_waddr;
        logic [DATA_W-1:0]     rkd_value;
        logic                  op_b;
        logic                  op_h;
        logic                  op_u;
    } id_to_ex_t;

    // Execute -> memory bus, MSB first.
    typedef struct packed {
        logic [DATA_W-1:0]     pc;
        logic                  res_from_mem;
        logic                  rf_we;
        logic [REG_ADDR_W-1:0] rf_waddr;
        logic [DATA_W-1:0]     result;
        logic [DATA_W-1:0]     rkd_value;
        logic [DATA_W-1:0]     sram_addr;
        logic                  op_b;
        logic                  op_h;
        logic                  op_u;
    } ex_to_mem_t;

    localparam int ID_TO_EX_W  = $bits(id_to_ex_t);
    localparam int EX_TO_MEM_W = $bits(ex_to_mem_t);
    localparam int EX_TO_ID_W  = 1 + REG_ADDR_W + DATA_W + 1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Combinational integer ALU with a one-hot operation select.
//   alu_op[0] add   [1] sub   [2] slt   [3] sltu  [4] and   [5] nor
//   alu_op[6] or    [7] xor   [8] sll   [9] srl   [10] sra  [11] lui
// Ports:
//   alu_op      in  12  one-hot operation select (all-zero gives 0)
//   alu_src1    in  32  first operand
//   alu_src2    in  32  second operand / shift amount in [4:0]
//   alu_result  out 32  result
// ---------------------------------------------------------------------------
module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);

    logic signed [31:0] src1_s;
    logic signed [31:0] src2_s;
    logic        [4:0]  shamt;

    assign src1_s = alu_src1;
    assign src2_s = alu_src2;
    assign shamt  = alu_src2[4:0];

    always_comb begin
        alu_result = '0;
        if (alu_op[0])  alu_result = alu_result | (alu_src1 + alu_src2);
        if (alu_op[1])  alu_result = alu_result | (alu_src1 - alu_src2);
        if (alu_op[2])  alu_result = alu_result | {31'b0, src1_s < src2_s};
        if (alu_op[3])  alu_result = alu_result | {31'b0, alu_src1 < alu_src2};
        if (alu_op[4])  alu_result = alu_result | (alu_src1 & alu_src2);
        if (alu_op[5])  alu_result = alu_result | ~(alu_src1 | alu_src2);
        if (alu_op[6])  alu_result = alu_result | (alu_src1 | alu_src2);
        if (alu_op[7])  alu_result = alu_result | (alu_src1 ^ alu_src2);
        if (alu_op[8])  alu_result = alu_result | (alu_src1 << shamt);
        if (alu_op[9])  alu_result = alu_result | (alu_src1 >> shamt);
        if (alu_op[10]) alu_result = alu_result | 32'(src1_s >>> shamt);
        if (alu_op[11]) alu_result = alu_result | alu_src2;
    end

endmodule

// File: rtl/ex_stage_div_div_iter.sv
// ---------------------------------------------------------------------------
// div_iter
// Iterative restoring divider, one quotient bit per cycle.
// IDLE -> CALC on start (operand magnitudes captured), CALC runs
// DIV_CYCLES iterations, then DONE holds the result until ack.
// Ports:
//   clk, reset  in   clock, asynchronous active-high reset
//   start       in   begin a division (only honoured in IDLE)
//   is_signed   in   treat operands as two's complement
//   dividend    in   32-bit dividend
//   divisor     in   32-bit divisor
//   ack         in   result consumed; DONE returns to IDLE
//   done        out  result valid (registered, high throughout DONE)
//   quotient    out  signed/unsigned quotient, valid while done
//   remainder   out  signed/unsigned remainder, valid while done
// ---------------------------------------------------------------------------
module div_iter
    import ex_stage_div_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        ack,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(DIV_CYCLES - 1);

    div_state_e           state;
    logic [DIV_CNT_W-1:0] count;
    logic                 done_flag;
    // Dividend bits shift out of the top while quotient bits shift in.
    logic [31:0]          work;
    logic [31:0]          rem;
    logic [31:0]          dsor_mag;
    logic [31:0]          dividend_raw;
    logic                 q_neg;
    logic                 r_neg;
    logic                 by_zero;

    logic [32:0]          trial;
    logic [31:0]          rem_next;
    logic [31:0]          work_next;

    function automatic logic [31:0] magnitude(input logic [31:0] x, input logic sgn);
        logic signed [31:0] xs;
        xs = x;
        // -0x80000000 wraps to 0x80000000, which is the correct magnitude.
        return (sgn && xs < 0) ? 32'(-xs) : x;
    endfunction

    // Apply result signs and the divide-by-zero convention.
    function automatic logic [63:0] finish(input logic [31:0] q_mag, input logic [31:0] r_mag,
                                           input logic qn, input logic rn, input logic dz,
                                           input logic [31:0] a_raw);
        logic [31:0] q;
        logic [31:0] r;
        q = qn ? 32'(-q_mag) : q_mag;
        r = rn ? 32'(-r_mag) : r_mag;
        if (dz) begin
            q = 32'hFFFF_FFFF;
            r = a_raw;
        end
        return {q, r};
    endfunction

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits.
    always_comb begin
        trial     = {rem, work[31]} - {1'b0, dsor_mag};
        rem_next  = {rem[30:0], work[31]};
        work_next = {work[30:0], 1'b0};
        if (!trial[32]) begin
            rem_next  = trial[31:0];
            work_next = {work[30:0], 1'b1};
        end
    end

    assign done = done_flag;
    assign {quotient, remainder} = finish(work, rem, q_neg, r_neg, by_zero, dividend_raw);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= DIV_IDLE;
            count        <= '0;
            done_flag    <= 1'b0;
            work         <= '0;
            rem          <= '0;
            dsor_mag     <= '0;
            dividend_raw <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            by_zero      <= 1'b0;
        end else begin
            unique case (state)
                DIV_IDLE: begin
                    if (start) begin
                        state        <= DIV_CALC;
                        count        <= '0;
                        work         <= magnitude(dividend, is_signed);
                        rem          <= '0;
                        dsor_mag     <= magnitude(divisor, is_signed);
                        dividend_raw <= dividend;
                        q_neg        <= is_signed & (dividend[31] ^ divisor[31]);
                        r_neg        <= is_signed & dividend[31];
                        by_zero      <= (divisor == 32'd0);
                    end
                end
                DIV_CALC: begin
                    work  <= work_next;
                    rem   <= rem_next;
                    count <= count + 1'b1;
                    if (count == LAST_CNT) begin
                        state     <= DIV_DONE;
                        done_flag <= 1'b1;
                    end
                end
                DIV_DONE: begin
                    if (ack) begin
                        state     <= DIV_IDLE;
                        done_flag <= 1'b0;
                        count     <= '0;
                    end
                end
                default: begin
                    state     <= DIV_IDLE;
                    done_flag <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_stage_div.sv
// ---------------------------------------------------------------------------
// ex_stage_div
// Execute stage of the 5-stage in-order pipeline. Latches one decoded
// instruction, computes its result with the combinational alu or the
// iterative divider, issues the data-SRAM request for loads/stores and
// drives the forwarding/stall bus back to decode.
// Ports:
//   clk, reset        in   clock, asynchronous active-high reset
//   id_to_ex_valid    in   decode holds a valid instruction
//   id_to_ex_bus      in   decoded instruction (id_to_ex_t layout)
//   ex_allowin        out  this stage can accept an instruction
//   mem_allowin       in   memory stage can accept an instruction
//   ex_to_mem_valid   out  completed instruction presented to memory
//   ex_to_mem_bus     out  ex_to_mem_t layout
//   ex_to_id_bus      out  {rf_we, rf_waddr, result, stall}
//   data_sram_en      out  data-SRAM request
//   data_sram_we      out  byte write strobes
//   data_sram_addr    out  data-SRAM address
//   data_sram_wdata   out  data-SRAM write data
// ---------------------------------------------------------------------------
module ex_stage_div
    import ex_stage_div_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_to_ex_valid,
    input  logic [ID_TO_EX_W-1:0]  id_to_ex_bus,
    output logic                   ex_allowin,
    input  logic                   mem_allowin,
    output logic                   ex_to_mem_valid,
    output logic [EX_TO_MEM_W-1:0] ex_to_mem_bus,
    output logic [EX_TO_ID_W-1:0]  ex_to_id_bus,
    output logic                   data_sram_en,
    output logic [3:0]             data_sram_we,
    output logic [31:0]            data_sram_addr,
    output logic [31:0]            data_sram_wdata
);

    id_to_ex_t   ex_instr;
    ex_to_mem_t  mem_bus;
    logic        ex_valid;
    logic        ex_ready_go;
    logic        is_div;
    logic        div_done;
    logic [31:0] alu_result;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [31:0] ex_result;

    function automatic logic [3:0] byte_strobe(input logic [1:0] addr_lo,
                                               input logic b, input logic h);
        if (b) return 4'b0001 << addr_lo;
        if (h) return 4'b0011 << {addr_lo[1], 1'b0};
        return 4'b1111;
    endfunction

    function automatic logic [31:0] store_data(input logic [31:0] v,
                                               input logic b, input logic h);
        if (b) return {4{v[7:0]}};
        if (h) return {2{v[15:0]}};
        return v;
    endfunction

    // Handshake
    assign is_div          = ex_instr.div_op[DIV_IS_DIV];
    assign ex_ready_go     = ~is_div | div_done;
    assign ex_allowin      = ~ex_valid | (ex_ready_go & mem_allowin);
    assign ex_to_mem_valid = ex_valid & ex_ready_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ex_instr <= '0;
        end else begin
            if (ex_allowin) begin
                ex_valid <= id_to_ex_valid;
            end
            if (id_to_ex_valid && ex_allowin) begin
                ex_instr <= id_to_ex_t'(id_to_ex_bus);
            end
        end
    end

    alu u_alu (
        .alu_op     (ex_instr.alu_op),
        .alu_src1   (ex_instr.alu_src1),
        .alu_src2   (ex_instr.alu_src2),
        .alu_result (alu_result)
    );

    // Starts only while idle; once DONE, start drops so the same
    // instruction is not divided twice.
    div_iter #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (ex_valid & is_div & ~div_done),
        .is_signed (ex_instr.div_op[DIV_SIGNED]),
        .dividend  (ex_instr.alu_src1),
        .divisor   (ex_instr.alu_src2),
        .ack       (ex_to_mem_valid & mem_allowin),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_comb begin
        ex_result = alu_result;
        if (is_div) begin
            ex_result = ex_instr.div_op[DIV_WANT_REM] ? remainder : quotient;
        end
    end

    // Execute -> memory bus
    always_comb begin
        mem_bus.pc           = ex_instr.pc;
        mem_bus.res_from_mem = ex_instr.res_from_mem;
        mem_bus.rf_we        = ex_instr.rf_we;
        mem_bus.rf_waddr     = ex_instr.rf_waddr;
        mem_bus.result       = ex_result;
        mem_bus.rkd_value    = ex_instr.rkd_value;
        mem_bus.sram_addr    = alu_result;
        mem_bus.op_b         = ex_instr.op_b;
        mem_bus.op_h         = ex_instr.op_h;
        mem_bus.op_u         = ex_instr.op_u;
    end

    assign ex_to_mem_bus = mem_bus;

    // Stall decode for a load (data not yet back) or an unfinished divide.
    assign ex_to_id_bus = {ex_valid & ex_instr.rf_we,
                           ex_instr.rf_waddr,
                           ex_result,
                           ex_valid & (ex_instr.res_from_mem | ~ex_ready_go)};

    // Data SRAM request fires on the same edge the instruction moves on.
    assign data_sram_en    = ex_valid & ex_ready_go & mem_allowin
                           & (ex_instr.res_from_mem | ex_instr.mem_we);
    assign data_sram_addr  = alu_result;
    assign data_sram_we    = (ex_instr.mem_we & data_sram_en)
                           ? byte_strobe(alu_result[1:0], ex_instr.op_b, ex_instr.op_h)
                           : 4'b0000;
    assign data_sram_wdata = store_data(ex_instr.rkd_value, ex_instr.op_b, ex_instr.op_h);

endmodule

// File: tb/tb_ex_stage_div.sv
`timescale 1ns/1ps
module tb_ex_stage_div;

    localparam int IW = 154;
    localparam logic [11:0] OP_ADD = 12'h001;
    localparam logic [11:0] OP_SUB = 12'h002;
    localparam logic [11:0] OP_SLT = 12'h004;
    localparam logic [11:0] OP_SRA = 12'h400;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_to_ex_valid;
    logic [IW-1:0] id_to_ex_bus;
    logic          ex_allowin;
    logic          mem_allowin;
    logic          ex_to_mem_valid;
    logic [137:0]  ex_to_mem_bus;
    logic [38:0]   ex_to_id_bus;
    logic          data_sram_en;
    logic [3:0]    data_sram_we;
    logic [31:0]   data_sram_addr;
    logic [31:0]   data_sram_wdata;

    always #5 clk = ~clk;

    ex_stage_div dut (
        .clk             (clk),
        .reset           (reset),
        .id_to_ex_valid  (id_to_ex_valid),
        .id_to_ex_bus    (id_to_ex_bus),
        .ex_allowin      (ex_allowin),
        .mem_allowin     (mem_allowin),
        .ex_to_mem_valid (ex_to_mem_valid),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_id_bus    (ex_to_id_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [IW-1:0] pack(input logic [11:0] op, input logic [31:0] s1,
                                           input logic [31:0] s2, input logic [2:0] dop,
                                           input logic rfm, input logic mwe,
                                           input logic [31:0] rkd, input logic b, input logic h);
        return {32'h1c00_0040, op, s1, s2, dop, rfm, mwe, 1'b1, 5'd4, rkd, b, h, 1'b0};
    endfunction

    function automatic logic [31:0] res_field();
        return ex_to_mem_bus[98:67];
    endfunction

    // Reference divider from the arithmetic definition.
    function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                              input logic sgn, input logic want_rem);
        longint sa, sb, q, r;
        if (b == 32'd0) return want_rem ? a : 32'hFFFF_FFFF;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return want_rem ? r[31:0] : q[31:0];
    endfunction

    // Issue one instruction, wait (bounded) for it to complete and let it
    // transfer with mem_allowin=1. lat counts cycles after the entry cycle.
    task automatic exec(input logic [IW-1:0] b, output logic [31:0] res,
                        output int lat, output bit stall_ok);
        id_to_ex_valid = 1'b1;
        id_to_ex_bus   = b;
        @(posedge clk); #1;
        id_to_ex_valid = 1'b0;
        lat      = 0;
        stall_ok = 1'b1;
        while (ex_to_mem_valid !== 1'b1 && lat < 100) begin
            if (ex_to_id_bus[0] !== 1'b1) stall_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        res = res_field();
        if (ex_to_id_bus[0] !== 1'b0) stall_ok = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic mem_check(input string name, input logic [IW-1:0] b, input logic [31:0] addr,
                             input logic [3:0] we, input logic [31:0] wdata, input logic stall);
        id_to_ex_valid = 1'b1;
        id_to_ex_bus   = b;
        @(posedge clk); #1;
        id_to_ex_valid = 1'b0;
        check({name, " en"}, data_sram_en, 1'b1);
        check({name, " addr"}, data_sram_addr, addr);
        check({name, " we"}, data_sram_we, we);
        if (we != 4'b0000) check({name, " wdata"}, data_sram_wdata, wdata);
        check({name, " stall"}, ex_to_id_bus[0], stall);
        check({name, " allowin"}, ex_allowin, 1'b1);
        @(posedge clk); #1;
        check({name, " en after"}, data_sram_en, 1'b0);
    endtask

    typedef struct {
        logic [11:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  dop;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    initial begin
        vec_t        vec[$];
        logic [31:0] res;
        logic [31:0] held;
        int          lat;
        int          cnt;
        bit          stall_ok;

        vec.push_back('{OP_ADD, 32'd5,          32'd7,          3'b000, 32'd12,         0});
        vec.push_back('{OP_SUB, 32'd5,          32'd7,          3'b000, 32'hFFFF_FFFE,  0});
        vec.push_back('{OP_SLT, 32'hFFFF_FFFF,  32'd1,          3'b000, 32'd1,          0});
        vec.push_back('{OP_SRA, 32'h8000_0000,  32'd4,          3'b000, 32'hF800_0000,  0});
        vec.push_back('{12'h0,  32'hFFFF_FFF9,  32'd2,          3'b110, 32'hFFFF_FFFD,  33});
        vec.push_back('{12'h0,  32'hFFFF_FFF9,  32'd2,          3'b111, 32'hFFFF_FFFF,  33});
        vec.push_back('{12'h0,  32'd100,        32'd0,          3'b100, 32'hFFFF_FFFF,  33});
        vec.push_back('{12'h0,  32'd100,        32'd0,          3'b101, 32'd100,        33});
        vec.push_back('{12'h0,  32'h8000_0000,  32'hFFFF_FFFF,  3'b110, 32'h8000_0000,  33});
        vec.push_back('{12'h0,  32'h8000_0000,  32'hFFFF_FFFF,  3'b111, 32'd0,          33});
        vec.push_back('{12'h0,  32'd7,          32'hFFFF_FFFE,  3'b110, 32'hFFFF_FFFD,  33});
        vec.push_back('{12'h0,  32'd7,          32'hFFFF_FFFE,  3'b111, 32'd1,          33});
        vec.push_back('{12'h0,  32'hFFFF_FFFB,  32'd0,          3'b110, 32'hFFFF_FFFF,  33});
        vec.push_back('{12'h0,  32'hFFFF_FFFB,  32'd0,          3'b111, 32'hFFFF_FFFB,  33});
        vec.push_back('{12'h0,  32'hFFFF_FFFF,  32'd3,          3'b100, 32'h5555_5555,  33});

        reset          = 1'b1;
        id_to_ex_valid = 1'b0;
        id_to_ex_bus   = '0;
        mem_allowin    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst ex_to_mem_valid", ex_to_mem_valid, 1'b0);
        check("rst sram_en", data_sram_en, 1'b0);
        check("rst sram_we", data_sram_we, 4'b0000);
        check("rst ex_to_id_bus", ex_to_id_bus, 39'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post-rst allowin", ex_allowin, 1'b1);
        check("post-rst valid", ex_to_mem_valid, 1'b0);

        // Table-driven ALU / divide vectors
        foreach (vec[i]) begin
            exec(pack(vec[i].op, vec[i].a, vec[i].b, vec[i].dop, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0),
                 res, lat, stall_ok);
            check($sformatf("vec%0d result", i), res, vec[i].exp);
            check($sformatf("vec%0d latency", i), lat, vec[i].lat);
            check($sformatf("vec%0d stall", i), stall_ok, 1'b1);
        end

        // Randomised divides against the arithmetic model
        for (int n = 0; n < 30; n++) begin
            logic [31:0] a, b;
            logic [1:0]  mode;
            int          sel;
            a    = $urandom;
            b    = $urandom;
            mode = 2'($urandom_range(0, 3));
            sel  = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel < 5) b = 32'($urandom_range(1, 50));
            else if (sel == 5) b = 32'hFFFF_FFFF;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            exec(pack(12'h0, a, b, {1'b1, mode}, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0), res, lat, stall_ok);
            check($sformatf("rnd%0d %0h/%0h m%0d", n, a, b, mode), res,
                  model_div(a, b, mode[1], mode[0]));
            check($sformatf("rnd%0d latency", n), lat, 33);
        end

        // Stores and a load
        mem_check("st.b", pack(OP_ADD, 32'h1000, 32'h3, 3'b000, 1'b0, 1'b1, 32'h1234_56AB, 1'b1, 1'b0),
                  32'h1003, 4'b1000, 32'hABAB_ABAB, 1'b0);
        mem_check("st.h", pack(OP_ADD, 32'h1000, 32'h2, 3'b000, 1'b0, 1'b1, 32'h1234_56AB, 1'b0, 1'b1),
                  32'h1002, 4'b1100, 32'h56AB_56AB, 1'b0);
        mem_check("st.w", pack(OP_ADD, 32'h1000, 32'h1, 3'b000, 1'b0, 1'b1, 32'h1234_56AB, 1'b0, 1'b0),
                  32'h1001, 4'b1111, 32'h1234_56AB, 1'b0);
        mem_check("ld.w", pack(OP_ADD, 32'h2000, 32'h8, 3'b000, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0),
                  32'h2008, 4'b0000, 32'd0, 1'b1);

        // Divide completes while memory stage is blocked
        mem_allowin    = 1'b0;
        id_to_ex_valid = 1'b1;
        id_to_ex_bus   = pack(12'h0, 32'd100, 32'd7, 3'b110, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        id_to_ex_valid = 1'b0;
        lat = 0;
        while (ex_to_mem_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("blocked div latency", lat, 33);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("blocked%0d valid", k), ex_to_mem_valid, 1'b1);
            check($sformatf("blocked%0d result", k), res_field(), 32'd14);
            check($sformatf("blocked%0d allowin", k), ex_allowin, 1'b0);
            check($sformatf("blocked%0d sram_en", k), data_sram_en, 1'b0);
            @(posedge clk); #1;
        end
        mem_allowin = 1'b1;
        #1;
        check("release allowin", ex_allowin, 1'b1);
        @(posedge clk); #1;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            if (ex_to_mem_valid === 1'b1) cnt++;
            @(posedge clk); #1;
        end
        check("single transfer", cnt, 0);

        // Back-to-back divides: second enters on the edge the first leaves
        id_to_ex_valid = 1'b1;
        id_to_ex_bus   = pack(12'h0, 32'd1000, 32'd9, 3'b100, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        id_to_ex_bus   = pack(12'h0, 32'd1000, 32'd9, 3'b101, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        lat = 0;
        while (ex_to_mem_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b first latency", lat, 33);
        check("b2b first result", res_field(), 32'd111);
        @(posedge clk); #1;
        id_to_ex_valid = 1'b0;
        lat = 0;
        while (ex_to_mem_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b second latency", lat, 33);
        check("b2b second result", res_field(), 32'd1);
        @(posedge clk); #1;

        // Reset in the middle of a divide
        id_to_ex_valid = 1'b1;
        id_to_ex_bus   = pack(12'h0, 32'd50, 32'd5, 3'b110, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        id_to_ex_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("pre-rst stall", ex_to_id_bus[0], 1'b1);
        reset = 1'b1;
        #1;
        check("mid-div rst valid", ex_to_mem_valid, 1'b0);
        check("mid-div rst id_bus", ex_to_id_bus, 39'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (ex_to_mem_valid === 1'b1) cnt++;
            @(posedge clk); #1;
        end
        check("no emit after rst", cnt, 0);
        exec(pack(OP_ADD, 32'd5, 32'd7, 3'b000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0), res, lat, stall_ok);
        check("post-rst add result", res, 32'd12);
        check("post-rst add latency", lat, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
